// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the 9-bit simple processor control path.
// Holds the opcode constants, the time-step enum, and helpers that slice
// the III / XXX / YYY fields out of a 9-bit instruction word.
// ---------------------------------------------------------------------------
package proc_pkg;

    localparam int INSTR_W = 9;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    function automatic logic [2:0] get_iii(input logic [INSTR_W-1:0] instr);
        return instr[8:6];
    endfunction

    function automatic logic [2:0] get_xxx(input logic [INSTR_W-1:0] instr);
        return instr[5:3];
    endfunction

    function automatic logic [2:0] get_yyy(input logic [INSTR_W-1:0] instr);
        return instr[2:0];
    endfunction

endpackage

// File: rtl/dec3to8.sv
// ---------------------------------------------------------------------------
// dec3to8
// 3-to-8 one-hot decoder with enable. Output bit y[w] is set when en is
// high; with en low the output is all zeros.
// Ports:
//   w   in  3      select
//   en  in  1      enable
//   y   out [0:7]  one-hot result (y[0] is the leftmost bit)
// ---------------------------------------------------------------------------
module dec3to8 (
    input  logic [2:0] w,
    input  logic       en,
    output logic [0:7] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[w] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_ctrl.sv
// ---------------------------------------------------------------------------
// proc_ctrl
// Control unit for the 9-bit simple processor. Latches an instruction from
// DIN in T0 when Run is high, then walks through T1..T3 asserting the strobes
// that sequence the shared-bus datapath (register file, A, G, adder/sub).
// All outputs are combinational from the step register and IR.
// Ports:
//   Clock   in   1      system clock
//   Resetn  in   1      asynchronous active-low reset
//   Run     in   1      start request, sampled only in T0
//   DIN     in   9      instruction word (T0) / immediate data (T1 of mvi)
//   Rin     out  [0:7]  register load enables, one-hot or zero
//   Rout    out  [0:7]  register bus-drive enables, one-hot or zero
//   Ain     out  1      load A from bus
//   Gin     out  1      load G from adder/subtractor
//   Gout    out  1      G drives bus
//   DINout  out  1      DIN drives bus
//   AddSub  out  1      0 = add, 1 = subtract
//   Done    out  1      final step of current instruction
// ---------------------------------------------------------------------------
module proc_ctrl
    import proc_pkg::*;
(
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] DIN,
    output logic [0:7] Rin,
    output logic [0:7] Rout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic       DINout,
    output logic       AddSub,
    output logic       Done
);

    step_t      step;
    step_t      step_next;
    logic [8:0] ir;

    logic       rin_en;
    logic       rout_en;
    logic [2:0] rout_sel;

    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;

    assign opcode = get_iii(ir);
    assign rx     = get_xxx(ir);
    assign ry     = get_yyy(ir);

    // Step register and instruction register. The IR is only written in T0
    // on a Run request, so later steps always decode the latched word and
    // never the live DIN bus.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step <= T0;
            ir   <= '0;
        end else begin
            step <= step_next;
            if (step == T0 && Run) begin
                ir <= DIN;
            end
        end
    end

    // Next-step and strobe decode. Only one bus driver (Rout, Gout or DINout)
    // is ever raised in a given step. Rin always targets Rx; Rout targets Ry
    // for mv and for the second operand of add/sub, but Rx when loading A.
    // Undefined opcodes finish in T1 with Done alone, behaving as a NOP.
    always_comb begin
        step_next = step;
        rin_en    = 1'b0;
        rout_en   = 1'b0;
        rout_sel  = ry;
        Ain       = 1'b0;
        Gin       = 1'b0;
        Gout      = 1'b0;
        DINout    = 1'b0;
        AddSub    = 1'b0;
        Done      = 1'b0;

        case (step)
            T0: begin
                if (Run) begin
                    step_next = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        rout_en   = 1'b1;
                        rout_sel  = ry;
                        rin_en    = 1'b1;
                        Done      = 1'b1;
                        step_next = T0;
                    end
                    OP_MVI: begin
                        DINout    = 1'b1;
                        rin_en    = 1'b1;
                        Done      = 1'b1;
                        step_next = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_en   = 1'b1;
                        rout_sel  = rx;
                        Ain       = 1'b1;
                        step_next = T2;
                    end
                    default: begin
                        Done      = 1'b1;
                        step_next = T0;
                    end
                endcase
            end
            T2: begin
                rout_en   = 1'b1;
                rout_sel  = ry;
                Gin       = 1'b1;
                AddSub    = ir[6];
                step_next = T3;
            end
            T3: begin
                Gout      = 1'b1;
                rin_en    = 1'b1;
                Done      = 1'b1;
                step_next = T0;
            end
            default: begin
                step_next = T0;
            end
        endcase
    end

    dec3to8 u_rin_dec (
        .w  (rx),
        .en (rin_en),
        .y  (Rin)
    );

    dec3to8 u_rout_dec (
        .w  (rout_sel),
        .en (rout_en),
        .y  (Rout)
    );

endmodule

// File: tb/tb_proc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_proc_ctrl
// Directed self-checking bench for proc_ctrl. Inputs are driven on the
// falling edge and outputs are sampled on the following falling edge, after
// the rising edge has moved the FSM.
// ---------------------------------------------------------------------------
module tb_proc_ctrl;

    logic       Clock;
    logic       Resetn;
    logic       Run;
    logic [8:0] DIN;
    logic [0:7] Rin;
    logic [0:7] Rout;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic       DINout;
    logic       AddSub;
    logic       Done;

    int compareCount;
    int mismatchCount;

    localparam logic [8:0] JUNK_WORD = 9'b000_111_111;

    proc_ctrl dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .DIN    (DIN),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .DINout (DINout),
        .AddSub (AddSub),
        .Done   (Done)
    );

    // 10-unit clock period, rising edges at 5, 15, 25, ...
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Packs every output into one vector, ordered
    // {Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done}.
    function automatic logic [21:0] packExpected(
        input logic [7:0] rin, input logic [7:0] rout,
        input logic ain, input logic gin, input logic gout,
        input logic dinout, input logic addsub, input logic done);
        return {rin, rout, ain, gin, gout, dinout, addsub, done};
    endfunction

    function automatic logic [21:0] observed();
        return {Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done};
    endfunction

    task automatic checkOutput(input string tag, input logic [21:0] obs,
                               input logic [21:0] exp);
        compareCount++;
        if (obs !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    // Drives Run/DIN, lets one rising edge consume them, and returns on the
    // next falling edge so outputs can be sampled mid-cycle.
    task automatic applyStimulus(input logic run, input logic [8:0] din);
        Run = run;
        DIN = din;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    localparam logic [21:0] IDLE = 22'd0;

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        Resetn = 1'b0;
        Run    = 1'b0;
        DIN    = 9'd0;

        // Reset state
        #12;
        checkOutput("reset_outputs", observed(), IDLE);
        checkOutput("reset_ir", {13'd0, dut.ir}, 22'd0);
        Resetn = 1'b1;

        // Idle with Run low: outputs stay 0 and IR is not loaded
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 9'b010_001_010);
            checkOutput("idle_outputs", observed(), IDLE);
        end
        checkOutput("idle_ir", {13'd0, dut.ir}, 22'd0);

        // mvi R0,#5
        applyStimulus(1'b1, 9'b001_000_000);
        Run = 1'b0;
        DIN = 9'd5;
        checkOutput("mvi_t1", observed(),
                    packExpected(8'b1000_0000, 8'b0, 0, 0, 0, 1, 0, 1));
        applyStimulus(1'b0, 9'd5);
        checkOutput("mvi_back_t0", observed(), IDLE);

        // mv R3,R0
        applyStimulus(1'b1, 9'b000_011_000);
        checkOutput("mv_t1", observed(),
                    packExpected(8'b0001_0000, 8'b1000_0000, 0, 0, 0, 0, 0, 1));
        applyStimulus(1'b0, 9'd0);
        checkOutput("mv_back_t0", observed(), IDLE);

        // add R1,R2 then sub R1,R2 with Run held high; junk on DIN during
        // later steps must not disturb the latched instruction
        applyStimulus(1'b1, 9'b010_001_010);
        checkOutput("add_t1", observed(),
                    packExpected(8'b0, 8'b0100_0000, 1, 0, 0, 0, 0, 0));
        applyStimulus(1'b1, JUNK_WORD);
        checkOutput("add_t2", observed(),
                    packExpected(8'b0, 8'b0010_0000, 0, 1, 0, 0, 0, 0));
        applyStimulus(1'b1, JUNK_WORD);
        checkOutput("add_t3", observed(),
                    packExpected(8'b0100_0000, 8'b0, 0, 0, 1, 0, 0, 1));
        applyStimulus(1'b1, 9'b011_001_010);
        checkOutput("fetch_t0", observed(), IDLE);
        applyStimulus(1'b1, 9'b011_001_010);
        checkOutput("sub_t1", observed(),
                    packExpected(8'b0, 8'b0100_0000, 1, 0, 0, 0, 0, 0));
        applyStimulus(1'b1, JUNK_WORD);
        checkOutput("sub_t2", observed(),
                    packExpected(8'b0, 8'b0010_0000, 0, 1, 0, 0, 1, 0));
        applyStimulus(1'b1, JUNK_WORD);
        checkOutput("sub_t3", observed(),
                    packExpected(8'b0100_0000, 8'b0, 0, 0, 1, 0, 0, 1));
        applyStimulus(1'b0, 9'd0);
        checkOutput("sub_back_t0", observed(), IDLE);

        // add R2,R2 (Rx = Ry)
        applyStimulus(1'b1, 9'b010_010_010);
        checkOutput("dbl_t1", observed(),
                    packExpected(8'b0, 8'b0010_0000, 1, 0, 0, 0, 0, 0));
        applyStimulus(1'b0, 9'd0);
        checkOutput("dbl_t2", observed(),
                    packExpected(8'b0, 8'b0010_0000, 0, 1, 0, 0, 0, 0));
        applyStimulus(1'b0, 9'd0);
        checkOutput("dbl_t3", observed(),
                    packExpected(8'b0010_0000, 8'b0, 0, 0, 1, 0, 0, 1));
        applyStimulus(1'b0, 9'd0);

        // Asynchronous reset during T2 of add R1,R2
        applyStimulus(1'b1, 9'b010_001_010);
        applyStimulus(1'b0, 9'd0);
        checkOutput("rst_pre_t2", observed(),
                    packExpected(8'b0, 8'b0010_0000, 0, 1, 0, 0, 0, 0));
        #1 Resetn = 1'b0;
        #1;
        checkOutput("rst_async_drop", observed(), IDLE);
        checkOutput("rst_async_ir", {13'd0, dut.ir}, 22'd0);
        #1 Resetn = 1'b1;
        applyStimulus(1'b0, 9'b010_001_010);
        checkOutput("rst_release_idle1", observed(), IDLE);
        applyStimulus(1'b0, 9'd0);
        checkOutput("rst_release_idle2", observed(), IDLE);

        // Undefined opcode acts as a NOP
        applyStimulus(1'b1, 9'b111_101_010);
        checkOutput("nop_t1", observed(),
                    packExpected(8'b0, 8'b0, 0, 0, 0, 0, 0, 1));
        applyStimulus(1'b0, 9'd0);
        checkOutput("nop_back_t0", observed(), IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compareCount, mismatchCount);
        $finish;
    end

endmodule
